dmem_byte_sequencer: RTL and testbench

Controller that sequences the pipeline's byte-wide data RAM for byte, halfword and word accesses. Each access runs as a series of single-byte RAM cycles, big-endian, while the MEM stage is stalled. With the debug feature compiled in, it also arbitrates the RAM between the pipeline and a debug/loader port. It sits between the MEM stage and `dataram`.

---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_rr_arbiter.sv | 45 ++++
 rtl/dmem_byte_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dmem_byte_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-serial data RAM sequencer: access sizes, FSM states,
// bus owners and the load extension helper.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ASM_W  = 24;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Index of the final byte of an access; the 2'b11 encoding behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            SZ_BYTE: res = 2'd0;
            SZ_HALF: res = 2'd1;
            default: res = 2'd3;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [1:0]        size,
                                                      input logic              sgn,
                                                      input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        case (size)
            SZ_BYTE: res = {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_HALF: res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-requester round-robin arbiter (CPU vs debug) holding the last-served owner.
// Only instantiated when DMEM_DBG_PORT_EN is defined.
module dmem_rr_arbiter
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    output logic cpu_gnt_o,
    output logic dbg_gnt_o
);

    owner_e last_owner_q, last_owner_d;
    logic   cpu_gnt_c, dbg_gnt_c;

    // On a tie the port that was not served last wins.
    always_comb begin
        cpu_gnt_c    = 1'b0;
        dbg_gnt_c    = 1'b0;
        last_owner_d = last_owner_q;
        if (en_i) begin
            if (cpu_req_i && dbg_req_i) begin
                if (last_owner_q == OWN_DBG) cpu_gnt_c = 1'b1;
                else                         dbg_gnt_c = 1'b1;
            end else if (cpu_req_i) begin
                cpu_gnt_c = 1'b1;
            end else if (dbg_req_i) begin
                dbg_gnt_c = 1'b1;
            end
            if (cpu_gnt_c)      last_owner_d = OWN_CPU;
            else if (dbg_gnt_c) last_owner_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) last_owner_q <= OWN_DBG;
        else       last_owner_q <= last_owner_d;
    end

    assign cpu_gnt_o = cpu_gnt_c;
    assign dbg_gnt_o = dbg_gnt_c;

endmodule

// File: rtl/dmem_byte_sequencer.sv
// Sequences byte/half/word MEM-stage accesses as big-endian single-byte RAM cycles.
// Define DMEM_DBG_PORT_EN to add the debug/loader word port and round-robin arbitration.
module dmem_byte_sequencer
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
`ifdef DMEM_DBG_PORT_EN
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [BYTE_W-1:0] ram_wdata,
    input  logic [BYTE_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    owner_e            owner_q;
    logic              we_q, sgn_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ASM_W-1:0]  asm_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic              idle_c, cpu_gnt_c, dbg_gnt_c, accept_c, last_c;
    logic [1:0]        sel_c;
    logic [DATA_W-1:0] load_c;
    owner_e            req_owner_c;
    logic              req_we_c, req_sgn_c;
    logic [1:0]        req_size_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic [DATA_W-1:0] req_wdata_c;

    assign idle_c   = (state_q == IDLE) && !reset;
    assign accept_c = cpu_gnt_c | dbg_gnt_c;
    assign last_c   = (idx_q == last_idx(size_q));
    assign sel_c    = last_idx(size_q) - idx_q;
    assign load_c   = extend_load(size_q, sgn_q, {asm_q, ram_rdata});

`ifdef DMEM_DBG_PORT_EN
    logic [DATA_W-1:0] dbg_rdata_q;

    dmem_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (idle_c),
        .cpu_req_i (cpu_req),
        .dbg_req_i (dbg_req),
        .cpu_gnt_o (cpu_gnt_c),
        .dbg_gnt_o (dbg_gnt_c)
    );

    // Debug accesses are always unsigned words.
    always_comb begin
        req_owner_c = OWN_CPU;
        req_we_c    = cpu_we;
        req_size_c  = cpu_size;
        req_sgn_c   = cpu_signed;
        req_addr_c  = cpu_addr;
        req_wdata_c = cpu_wdata;
        if (dbg_gnt_c) begin
            req_owner_c = OWN_DBG;
            req_we_c    = dbg_we;
            req_size_c  = 2'(SZ_WORD);
            req_sgn_c   = 1'b0;
            req_addr_c  = dbg_addr;
            req_wdata_c = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata_q <= '0;
        end else if (state_q == XFER && !we_q && last_c && owner_q == OWN_DBG) begin
            dbg_rdata_q <= load_c;
        end
    end

    assign dbg_gnt   = dbg_gnt_c;
    assign dbg_done  = (state_q == DONE) && (owner_q == OWN_DBG) && !reset;
    assign dbg_rdata = dbg_rdata_q;
`else
    assign cpu_gnt_c   = idle_c && cpu_req;
    assign dbg_gnt_c   = 1'b0;
    assign req_owner_c = OWN_CPU;
    assign req_we_c    = cpu_we;
    assign req_size_c  = cpu_size;
    assign req_sgn_c   = cpu_signed;
    assign req_addr_c  = cpu_addr;
    assign req_wdata_c = cpu_wdata;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = XFER;
                    idx_d   = '0;
                end
            end
            XFER: begin
                if (last_c) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the write strobe is cut during reset so an aborted store stops at once.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state_q == XFER) begin
            ram_addr = addr_q + ADDR_W'(idx_q);
            if (we_q) begin
                ram_we    = !reset;
                ram_wdata = wdata_q[{sel_c, 3'b000} +: BYTE_W];
            end
        end
        cpu_stall = cpu_req && !reset && !((state_q == DONE) && (owner_q == OWN_CPU));
    end

    // Request latch and load assembly; results land on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            cpu_rdata_q <= '0;
        end else if (accept_c) begin
            owner_q <= req_owner_c;
            we_q    <= req_we_c;
            size_q  <= req_size_c;
            sgn_q   <= req_sgn_c;
            addr_q  <= req_addr_c;
            wdata_q <= req_wdata_c;
            asm_q   <= '0;
        end else if (state_q == XFER && !we_q) begin
            asm_q <= {asm_q[ASM_W-BYTE_W-1:0], ram_rdata};
            if (last_c && owner_q == OWN_CPU) cpu_rdata_q <= load_c;
        end
    end

    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Directed self-checking bench for dmem_byte_sequencer with a behavioural byte RAM.
// Debug-port scenarios are built only when DMEM_DBG_PORT_EN is defined.
module tb_dmem_byte_sequencer;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [1:0]        cpu_size = 2'b00;
    logic              cpu_signed = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
`ifdef DMEM_DBG_PORT_EN
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic              dbg_gnt;
    logic              dbg_done;
    logic [31:0]       dbg_rdata;
`endif
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;

    dmem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
`ifdef DMEM_DBG_PORT_EN
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_done   (dbg_done),
        .dbg_rdata  (dbg_rdata),
`endif
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    // Issues one CPU access and counts stalled cycles until the DONE cycle.
    task automatic run_cpu(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [7:0] addr, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rd);
        bit done;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
        cpu_addr = addr; cpu_wdata = wd;
        stalls = 0; rd = 32'hxxxx_xxxx; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (cpu_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                rd = cpu_rdata;
                done = 1;
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10;
        @(negedge clk);
        #1;
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_vec++; if (ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
        n_vec++; if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL reset_ram_wdata: got %h want 00", ram_wdata); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
`ifdef DMEM_DBG_PORT_EN
        n_vec++; if (dbg_gnt !== 1'b0 || dbg_done !== 1'b0) begin n_err++; $display("FAIL reset_dbg_pulses: got %b%b want 00", dbg_gnt, dbg_done); end
        n_vec++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dbg_rdata: got %h want 0", dbg_rdata); end
`endif
        @(negedge clk);
        cpu_req = 1'b0; reset = 1'b0;
    endtask

    task automatic test_word_store();
        int st; logic [31:0] rd;
        run_cpu(1'b1, 2'b10, 1'b0, 8'd56, 32'h1234_5678, st, rd);
        n_vec++; if (st !== 5) begin n_err++; $display("FAIL wstore_stall: got %0d want 5", st); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wstore_rdata_held: got %h want 0", rd); end
        n_vec++; if ({mem[56], mem[57], mem[58], mem[59]} !== 32'h1234_5678) begin
            n_err++; $display("FAIL wstore_mem: got %h%h%h%h want 12345678", mem[56], mem[57], mem[58], mem[59]); end
        n_vec++; if (mem[55] !== 8'h00 || mem[60] !== 8'h00) begin
            n_err++; $display("FAIL wstore_neighbours: got %h %h want 00 00", mem[55], mem[60]); end
        run_cpu(1'b0, 2'b10, 1'b0, 8'd56, 32'h0, st, rd);
        n_vec++; if (st !== 5) begin n_err++; $display("FAIL wload_stall: got %0d want 5", st); end
        n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL wload_data: got %h want 12345678", rd); end
    endtask

    task automatic test_byte_load();
        int st; logic [31:0] rd;
        mem[56] = 8'h80;
        run_cpu(1'b0, 2'b00, 1'b1, 8'd56, 32'h0, st, rd);
        n_vec++; if (st !== 2) begin n_err++; $display("FAIL bload_stall: got %0d want 2", st); end
        n_vec++; if (rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL bload_signed: got %h want ffffff80", rd); end
        run_cpu(1'b0, 2'b00, 1'b0, 8'd56, 32'h0, st, rd);
        n_vec++; if (rd !== 32'h0000_0080) begin n_err++; $display("FAIL bload_unsigned: got %h want 00000080", rd); end
        run_cpu(1'b1, 2'b00, 1'b0, 8'd57, 32'hFFFF_FF9C, st, rd);
        n_vec++; if (mem[57] !== 8'h9C || mem[58] !== 8'h56) begin
            n_err++; $display("FAIL bstore_mem: got %h %h want 9c 56", mem[57], mem[58]); end
    endtask

    task automatic test_half_wrap();
        int st; logic [31:0] rd;
        mem[255] = 8'hAB; mem[0] = 8'hCD;
        run_cpu(1'b0, 2'b01, 1'b0, 8'd255, 32'h0, st, rd);
        n_vec++; if (st !== 3) begin n_err++; $display("FAIL hload_stall: got %0d want 3", st); end
        n_vec++; if (rd !== 32'h0000_ABCD) begin n_err++; $display("FAIL hload_wrap: got %h want 0000abcd", rd); end
        run_cpu(1'b0, 2'b01, 1'b1, 8'd255, 32'h0, st, rd);
        n_vec++; if (rd !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL hload_signed: got %h want ffffabcd", rd); end
        mem[254] = 8'h01; mem[1] = 8'hEF;
        run_cpu(1'b0, 2'b11, 1'b1, 8'd254, 32'h0, st, rd);
        n_vec++; if (st !== 5) begin n_err++; $display("FAIL size11_stall: got %0d want 5", st); end
        n_vec++; if (rd !== 32'h01AB_CDEF) begin n_err++; $display("FAIL size11_word: got %h want 01abcdef", rd); end
        run_cpu(1'b1, 2'b01, 1'b0, 8'd255, 32'hDEAD_BEEF, st, rd);
        n_vec++; if (mem[255] !== 8'hBE || mem[0] !== 8'hEF || mem[1] !== 8'hEF || mem[254] !== 8'h01) begin
            n_err++; $display("FAIL hstore_wrap: got %h %h %h %h want 01 be ef ef", mem[254], mem[255], mem[0], mem[1]); end
        n_vec++; if (rd !== 32'h01AB_CDEF) begin n_err++; $display("FAIL hstore_rdata_held: got %h want 01abcdef", rd); end
    endtask

    task automatic test_back_to_back();
        int st1 = 0, st2 = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_signed = 1'b0;
        cpu_addr = 8'd10; cpu_wdata = 32'hA1A2_A3A4;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i < 6) begin
                if (cpu_stall) st1++;
                if (i == 5) begin cpu_addr = 8'd20; cpu_wdata = 32'hB1B2_B3B4; end
            end else begin
                if (cpu_stall) st2++;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        n_vec++; if (st1 !== 5 || st2 !== 5) begin n_err++; $display("FAIL b2b_stall: got %0d/%0d want 5/5", st1, st2); end
        n_vec++; if ({mem[10], mem[11], mem[12], mem[13]} !== 32'hA1A2_A3A4) begin
            n_err++; $display("FAIL b2b_first: got %h%h%h%h want a1a2a3a4", mem[10], mem[11], mem[12], mem[13]); end
        n_vec++; if ({mem[20], mem[21], mem[22], mem[23]} !== 32'hB1B2_B3B4) begin
            n_err++; $display("FAIL b2b_second: got %h%h%h%h want b1b2b3b4", mem[20], mem[21], mem[22], mem[23]); end
    endtask

    task automatic test_reset_mid_store();
        int st; logic [31:0] rd;
        for (int a = 56; a < 60; a++) mem[a] = 8'h00;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_signed = 1'b0;
        cpu_addr = 8'd56; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        #1;
        n_vec++; if (ram_addr !== 8'd56 || ram_wdata !== 8'h12 || ram_we !== 1'b1) begin
            n_err++; $display("FAIL abort_xfer0: got %h/%h/%b want 38/12/1", ram_addr, ram_wdata, ram_we); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL abort_we_cut: got %b want 0", ram_we); end
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b want 0", cpu_stall); end
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        n_vec++; if (ram_we !== 1'b0 || ram_addr !== 8'h00) begin
            n_err++; $display("FAIL abort_idle: got we=%b addr=%h want 0/00", ram_we, ram_addr); end
        n_vec++; if ({mem[56], mem[57], mem[58], mem[59]} !== 32'h1234_0000) begin
            n_err++; $display("FAIL abort_mem: got %h%h%h%h want 12340000", mem[56], mem[57], mem[58], mem[59]); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL abort_rdata_cleared: got %h want 0", cpu_rdata); end
        run_cpu(1'b0, 2'b10, 1'b0, 8'd56, 32'h0, st, rd);
        n_vec++; if (st !== 5 || rd !== 32'h1234_0000) begin
            n_err++; $display("FAIL abort_recover: got %0d/%h want 5/12340000", st, rd); end
    endtask

`ifdef DMEM_DBG_PORT_EN
    task automatic test_arbitration();
        logic es, eg, ed;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem[56] = 8'hDE; mem[57] = 8'hAD; mem[58] = 8'hBE; mem[59] = 8'hEF;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_signed = 1'b0;
        cpu_addr = 8'd100; cpu_wdata = 32'hCAFE_BABE;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd56; dbg_wdata = 32'h0;
        // CPU wins the first tie, debug the second, then the CPU load follows.
        for (int c = 0; c < 18; c++) begin
            #1;
            es = !(c == 5 || c == 17); eg = (c == 6); ed = (c == 11);
            n_vec++; if (cpu_stall !== es) begin n_err++; $display("FAIL arb1_stall c%0d: got %b want %b", c, cpu_stall, es); end
            n_vec++; if (dbg_gnt !== eg) begin n_err++; $display("FAIL arb1_gnt c%0d: got %b want %b", c, dbg_gnt, eg); end
            n_vec++; if (dbg_done !== ed) begin n_err++; $display("FAIL arb1_done c%0d: got %b want %b", c, dbg_done, ed); end
            if (c == 5) begin
                n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL arb1_store_rdata: got %h want 0", cpu_rdata); end
                cpu_we = 1'b0;
            end
            if (c == 11) begin
                n_vec++; if (dbg_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL arb1_dbg_rdata: got %h want deadbeef", dbg_rdata); end
                dbg_req = 1'b0;
            end
            if (c == 17) begin
                n_vec++; if (cpu_rdata !== 32'hCAFE_BABE) begin n_err++; $display("FAIL arb1_cpu_load: got %h want cafebabe", cpu_rdata); end
                cpu_req = 1'b0;
            end
            @(negedge clk);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0; cpu_addr = 8'd200;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd200; dbg_wdata = 32'h5566_7788;
        for (int c = 0; c < 9; c++) begin
            #1;
            es = (c != 8); eg = (c == 0); ed = (c == 5);
            n_vec++; if (cpu_stall !== es) begin n_err++; $display("FAIL arb2_stall c%0d: got %b want %b", c, cpu_stall, es); end
            n_vec++; if (dbg_gnt !== eg) begin n_err++; $display("FAIL arb2_gnt c%0d: got %b want %b", c, dbg_gnt, eg); end
            n_vec++; if (dbg_done !== ed) begin n_err++; $display("FAIL arb2_done c%0d: got %b want %b", c, dbg_done, ed); end
            if (c == 5) dbg_req = 1'b0;
            if (c == 8) begin
                n_vec++; if (cpu_rdata !== 32'h0000_0055) begin n_err++; $display("FAIL arb2_cpu_byte: got %h want 00000055", cpu_rdata); end
                cpu_req = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++; if ({mem[200], mem[201], mem[202], mem[203]} !== 32'h5566_7788) begin
            n_err++; $display("FAIL arb2_dbg_store: got %h%h%h%h want 55667788", mem[200], mem[201], mem[202], mem[203]); end
        n_vec++; if (dbg_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL arb2_dbg_rdata_held: got %h want deadbeef", dbg_rdata); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_wrap();
        test_back_to_back();
        test_reset_mid_store();
`ifdef DMEM_DBG_PORT_EN
        test_arbitration();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
